aurora_tx_arbiter: RTL

//   Shares the single 64-bit Aurora TX lane between N_PORTS encap_packet instances.
//   - Picks one requesting input port round-robin and issues that port's one-cycle arbiter_gnt.
//   - Holds the lane for exactly one frame (NUMBER_PACKET words) and muxes the granted port's words onto TX.
//   - Marks the last word, enforces an inter-frame gap, and aborts frames that stall or lose the link.

---
 rtl/aurora_tx_arbiter_if.sv | 33 +++
 rtl/aurora_tx_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/aurora_tx_arbiter_if.sv
// Bundle between the Aurora TX arbiter and its N_PORTS encap_packet
// requesters: request/grant, per-port words in, and the shared TX lane out.
interface aurora_tx_arbiter_if #(
  parameter int N_PORTS           = 4,
  parameter int AURORA_DATA_WIDTH = 64
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic                                   channel_up;
  logic [N_PORTS-1:0]                     req;
  logic [N_PORTS-1:0]                     arbiter_gnt;
  logic [N_PORTS*AURORA_DATA_WIDTH-1:0]   data_in;
  logic [N_PORTS-1:0]                     data_valid;
  logic [AURORA_DATA_WIDTH-1:0]           tx_tdata;
  logic                                   tx_tvalid;
  logic                                   tx_tlast;
  logic [PW-1:0]                          active_port;
  logic                                   busy;
  logic                                   frame_done;
  logic                                   frame_abort;

  modport master (
    input  channel_up, req, data_in, data_valid,
    output arbiter_gnt, tx_tdata, tx_tvalid, tx_tlast,
           active_port, busy, frame_done, frame_abort
  );

  modport slave (
    output channel_up, req, data_in, data_valid,
    input  arbiter_gnt, tx_tdata, tx_tvalid, tx_tlast,
           active_port, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/aurora_tx_arbiter.sv
// Round-robin owner of the single Aurora TX lane: grants one encap_packet port
// per frame, forwards exactly NUMBER_PACKET of its words, then forces a gap.
module aurora_tx_arbiter #(
  parameter int N_PORTS           = 4,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int NUMBER_PACKET     = 19,
  parameter int GAP_CYCLES        = 2,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                clk,
  input  logic                rst,
  aurora_tx_arbiter_if.master bus
);

  localparam int W        = AURORA_DATA_WIDTH;
  localparam int PW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int WCW      = $clog2(NUMBER_PACKET + 1);
  localparam int TCW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GCW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_GAP} state_t;

  // With no gap configured a finished frame returns straight to arbitration.
  localparam state_t POST_FRAME = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  winner;
  logic           any_req;
  logic [WCW-1:0] word_cnt;
  logic [TCW-1:0] timeout_cnt;
  logic [GCW-1:0] gap_cnt;
  logic [W-1:0]   act_data;
  logic           act_valid;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s = int'(base) + off;
    if (s >= N_PORTS) s -= N_PORTS;
    return PW'(s);
  endfunction

  // Scan offsets high-to-low so the closest requester at or after rr_ptr wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (bus.req[wrap_add(rr_ptr, i)]) begin
        winner  = wrap_add(rr_ptr, i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    act_data  = '0;
    act_valid = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (bus.active_port == PW'(i)) begin
        act_data  = bus.data_in[i*W +: W];
        act_valid = bus.data_valid[i];
      end
    end
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      rr_ptr          <= '0;
      word_cnt        <= '0;
      timeout_cnt     <= '0;
      gap_cnt         <= '0;
      bus.arbiter_gnt <= '0;
      bus.tx_tdata    <= '0;
      bus.tx_tvalid   <= 1'b0;
      bus.tx_tlast    <= 1'b0;
      bus.active_port <= '0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_abort <= 1'b0;
    end else begin
      bus.arbiter_gnt <= '0;
      bus.tx_tdata    <= '0;
      bus.tx_tvalid   <= 1'b0;
      bus.tx_tlast    <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_abort <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.channel_up && any_req) begin
            state           <= S_GRANT;
            bus.arbiter_gnt <= N_PORTS'(1) << winner;
            bus.active_port <= winner;
            bus.busy        <= 1'b1;
            word_cnt        <= '0;
            timeout_cnt     <= '0;
          end
        end

        // The encap_packet sees its grant this cycle; its words start later.
        S_GRANT: state <= S_XFER;

        S_XFER: begin
          if (!bus.channel_up) begin
            bus.frame_abort <= 1'b1;
            bus.busy        <= 1'b0;
            rr_ptr          <= wrap_add(bus.active_port, 1);
            gap_cnt         <= '0;
            state           <= POST_FRAME;
          end else if (act_valid) begin
            bus.tx_tdata  <= act_data;
            bus.tx_tvalid <= 1'b1;
            word_cnt      <= word_cnt + 1'b1;
            timeout_cnt   <= '0;
            if (word_cnt == WCW'(NUMBER_PACKET - 1)) begin
              bus.tx_tlast   <= 1'b1;
              bus.frame_done <= 1'b1;
              bus.busy       <= 1'b0;
              rr_ptr         <= wrap_add(bus.active_port, 1);
              gap_cnt        <= '0;
              state          <= POST_FRAME;
            end
          end else if (timeout_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
            bus.frame_abort <= 1'b1;
            bus.busy        <= 1'b0;
            rr_ptr          <= wrap_add(bus.active_port, 1);
            gap_cnt         <= '0;
            state           <= POST_FRAME;
          end else begin
            bus.tx_tdata <= act_data;
            timeout_cnt  <= timeout_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GCW'(GAP_LAST)) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
